// File: rtl/sprite_line_fetcher_if.sv
// sprite_line_fetcher_if
// Bundles every non-clock signal of the sprite line fetcher.
//   line_start / line_has_sprites : scanline kick-off from the display timing
//   spr_*                         : sprite entry stream from sprite evaluation
//   vram_read_addr / _data        : sprite VRAM read port (data one clock later)
//   lb_wr_*                       : scanline buffer write port
//   busy / line_done              : scanline status
//   state_dbg                     : fetcher FSM state, for observation only
// Modports: master = environment side, slave = the fetcher.
//
// Sprite entry handshake: an entry transfers on a rising clk edge where
// spr_valid and spr_ready are both 1. The producer holds spr_x,
// spr_line_addr and spr_last stable while spr_valid is 1 and not yet
// accepted; spr_ready never depends combinationally on spr_valid.
interface sprite_line_fetcher_if #(
    parameter int X_W    = 10,
    parameter int ADDR_W = 12
);
    logic              line_start;
    logic              line_has_sprites;
    logic              spr_valid;
    logic              spr_ready;
    logic [X_W-1:0]    spr_x;
    logic [ADDR_W-1:0] spr_line_addr;
    logic              spr_last;
    logic [ADDR_W-1:0] vram_read_addr;
    logic [255:0]      vram_read_data;
    logic              lb_wr_en;
    logic [X_W-1:0]    lb_wr_addr;
    logic [7:0]        lb_wr_data;
    logic              busy;
    logic              line_done;
    logic [2:0]        state_dbg;

    modport master (
        output line_start, line_has_sprites, spr_valid, spr_x, spr_line_addr,
               spr_last, vram_read_data,
        input  spr_ready, vram_read_addr, lb_wr_en, lb_wr_addr, lb_wr_data,
               busy, line_done, state_dbg
    );

    modport slave (
        input  line_start, line_has_sprites, spr_valid, spr_x, spr_line_addr,
               spr_last, vram_read_data,
        output spr_ready, vram_read_addr, lb_wr_en, lb_wr_addr, lb_wr_data,
               busy, line_done, state_dbg
    );
endinterface

// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
// Per scanline, accepts a priority-ordered list of sprite rows (lowest
// priority first), reads each 256-bit row from sprite VRAM and writes its
// opaque, on-screen pixels into the scanline buffer, one pixel per clock.
// Later sprites simply overwrite earlier ones; nothing is read back.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : sprite_line_fetcher_if.slave (see interface header for signals)
// Every output is a register.
module sprite_line_fetcher #(
    parameter int LINE_WIDTH = 640,
    parameter int X_W        = 10,
    parameter int ADDR_W     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    sprite_line_fetcher_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_CAPTURE,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [X_W:0] LINE_LIMIT = (X_W+1)'(LINE_WIDTH);

    state_t            state;
    logic [X_W-1:0]    x_q;
    logic              last_q;
    logic [4:0]        k_q;
    logic [255:0]      pix_q;

    logic [ADDR_W-1:0] vram_addr_q;
    logic              spr_ready_q;
    logic              wr_en_q;
    logic [X_W-1:0]    wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              busy_q;
    logic              done_q;

    // Screen positions carry one extra bit so a sprite hanging past 2^X_W
    // never wraps onto the left edge of the line.
    logic [4:0]        k_next;
    logic [X_W:0]      pos_first;
    logic [X_W:0]      pos_next;
    logic [7:0]        byte_first;
    logic [7:0]        byte_next;

    always_comb begin
        k_next     = k_q + 5'd1;
        pos_first  = {1'b0, x_q};
        pos_next   = {1'b0, x_q} + {{(X_W-4){1'b0}}, k_next};
        byte_first = bus.vram_read_data[255:248];
        // pix_q is shifted left one byte per pixel, so the following pixel
        // always sits in the second-highest byte.
        byte_next  = pix_q[247:240];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            x_q         <= '0;
            last_q      <= 1'b0;
            k_q         <= '0;
            pix_q       <= '0;
            vram_addr_q <= '0;
            spr_ready_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.line_start) begin
                        busy_q <= 1'b1;
                        if (bus.line_has_sprites) begin
                            state       <= S_WAIT;
                            spr_ready_q <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.spr_valid && spr_ready_q) begin
                        x_q         <= bus.spr_x;
                        last_q      <= bus.spr_last;
                        vram_addr_q <= bus.spr_line_addr;
                        spr_ready_q <= 1'b0;
                        state       <= S_READ;
                    end
                end
                S_READ: begin
                    // VRAM is returning the row during this cycle.
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // Pixel 0 comes straight from the read data so DRAW
                    // starts writing on its first cycle.
                    pix_q     <= bus.vram_read_data;
                    k_q       <= '0;
                    wr_addr_q <= x_q;
                    wr_data_q <= byte_first;
                    wr_en_q   <= (byte_first != 8'd0) && (pos_first < LINE_LIMIT);
                    state     <= S_DRAW;
                end
                S_DRAW: begin
                    if (k_q == 5'd31) begin
                        wr_en_q <= 1'b0;
                        if (last_q) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state       <= S_WAIT;
                            spr_ready_q <= 1'b1;
                        end
                    end else begin
                        k_q       <= k_next;
                        pix_q     <= pix_q << 8;
                        wr_addr_q <= pos_next[X_W-1:0];
                        wr_data_q <= byte_next;
                        wr_en_q   <= (byte_next != 8'd0) && (pos_next < LINE_LIMIT);
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.spr_ready      = spr_ready_q;
    assign bus.vram_read_addr = vram_addr_q;
    assign bus.lb_wr_en       = wr_en_q;
    assign bus.lb_wr_addr     = wr_addr_q;
    assign bus.lb_wr_data     = wr_data_q;
    assign bus.busy           = busy_q;
    assign bus.line_done      = done_q;
    assign bus.state_dbg      = state;
endmodule
